// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: resolves branch outcomes two cycles after br_valid, flags mispredicts,
// drives a multi-cycle flush and keeps saturating stats. Optional history: BRU_OUTCOME_HIST_EN.
module branch_resolve_unit #(
    parameter int unsigned DW           = 4,
    parameter int unsigned FLUSH_CYCLES = 3,
    parameter int unsigned CNT_W        = 16,
    parameter int unsigned HIST_LEN     = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                br_valid,
    input  logic [1:0]          br_op,
    input  logic [DW-1:0]       br_a,
    input  logic [DW-1:0]       br_b,
    input  logic                pred_taken,
    input  logic                stats_clr,
    output logic                resolve_valid,
    output logic                actual_taken,
    output logic                mispredict,
    output logic                flush,
    output logic [CNT_W-1:0]    br_cnt,
    output logic [CNT_W-1:0]    mispred_cnt,
    output logic [CNT_W-1:0]    squash_cnt,
    output logic [HIST_LEN-1:0] outcome_hist
);

    localparam int unsigned FC_W = $clog2(FLUSH_CYCLES + 1);

    localparam logic [1:0] OP_BEQ = 2'b00;
    localparam logic [1:0] OP_BNE = 2'b01;
    localparam logic [1:0] OP_BLT = 2'b10;
    localparam logic [1:0] OP_BGE = 2'b11;

    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } state_t;

    typedef struct packed {
        logic [1:0]    op;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
    } s1_t;

    state_t          state, state_nxt;
    logic [FC_W-1:0] fcnt, fcnt_nxt;

    logic s1_valid;
    s1_t  s1;

    logic       actual_c;
    logic       resolve_c;
    logic       mispred_c;
    logic [1:0] squash_inc_c;

    // Saturating add: an overflow out of the top bit pins the counter at all-ones
    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] cnt,
                                                 input logic [1:0]       inc);
        logic [CNT_W:0] sum;
        sum = {1'b0, cnt} + (CNT_W+1)'(inc);
        return sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
    endfunction

    // Stage 1: capture the branch unless a flush is in progress
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1       <= '0;
        end else begin
            s1_valid <= br_valid && !flush;
            if (br_valid && !flush) begin
                s1.op <= br_op;
                s1.a  <= br_a;
                s1.b  <= br_b;
            end
        end
    end

    // Stage 2 outcome evaluation and squash accounting
    always_comb begin
        actual_c = 1'b0;
        case (s1.op)
            OP_BEQ:  actual_c = (s1.a == s1.b);
            OP_BNE:  actual_c = (s1.a != s1.b);
            OP_BLT:  actual_c = (s1.a <  s1.b);
            OP_BGE:  actual_c = (s1.a >= s1.b);
            default: actual_c = 1'b0;
        endcase
        resolve_c    = s1_valid && !flush;
        mispred_c    = resolve_c && (actual_c != pred_taken);
        squash_inc_c = {1'b0, br_valid && flush} + {1'b0, s1_valid && flush};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resolve_valid <= 1'b0;
            actual_taken  <= 1'b0;
            mispredict    <= 1'b0;
        end else begin
            resolve_valid <= resolve_c;
            mispredict    <= mispred_c;
            if (resolve_c) begin
                actual_taken <= actual_c;
            end
        end
    end

    // Flush FSM state register; flush is registered off the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            fcnt  <= '0;
            flush <= 1'b0;
        end else begin
            state <= state_nxt;
            fcnt  <= fcnt_nxt;
            flush <= (state_nxt == FLUSH);
        end
    end

    always_comb begin
        state_nxt = state;
        fcnt_nxt  = fcnt;
        case (state)
            IDLE: begin
                if (mispred_c) begin
                    state_nxt = FLUSH;
                    fcnt_nxt  = FC_W'(FLUSH_CYCLES - 1);
                end
            end
            FLUSH: begin
                if (fcnt == '0) begin
                    state_nxt = IDLE;
                end else begin
                    fcnt_nxt = fcnt - FC_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                fcnt_nxt  = '0;
            end
        endcase
    end

    // Statistics; clear wins over any increment in the same cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            br_cnt      <= '0;
            mispred_cnt <= '0;
            squash_cnt  <= '0;
        end else if (stats_clr) begin
            br_cnt      <= '0;
            mispred_cnt <= '0;
            squash_cnt  <= '0;
        end else begin
            br_cnt      <= sat_add(br_cnt, {1'b0, resolve_c});
            mispred_cnt <= sat_add(mispred_cnt, {1'b0, mispred_c});
            squash_cnt  <= sat_add(squash_cnt, squash_inc_c);
        end
    end

`ifdef BRU_OUTCOME_HIST_EN
    // Outcome history, newest in bit 0; survives stats_clr
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outcome_hist <= '0;
        end else if (resolve_c) begin
            outcome_hist <= HIST_LEN'({outcome_hist, actual_c});
        end
    end
`else
    assign outcome_hist = '0;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed self-checking bench for branch_resolve_unit (default instance plus a CNT_W=2 instance).
module tb_branch_resolve_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       br_valid;
    logic [1:0] br_op;
    logic [3:0] br_a;
    logic [3:0] br_b;
    logic       pred_taken;
    logic       stats_clr;

    logic        resolve_valid, actual_taken, mispredict, flush;
    logic [15:0] br_cnt, mispred_cnt, squash_cnt;
    logic [7:0]  outcome_hist;

    logic        s_resolve_valid, s_actual_taken, s_mispredict, s_flush;
    logic [1:0]  s_br_cnt, s_mispred_cnt, s_squash_cnt;
    logic [7:0]  s_outcome_hist;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    branch_resolve_unit dut (
        .clk(clk), .rst_n(rst_n), .br_valid(br_valid), .br_op(br_op),
        .br_a(br_a), .br_b(br_b), .pred_taken(pred_taken), .stats_clr(stats_clr),
        .resolve_valid(resolve_valid), .actual_taken(actual_taken),
        .mispredict(mispredict), .flush(flush), .br_cnt(br_cnt),
        .mispred_cnt(mispred_cnt), .squash_cnt(squash_cnt), .outcome_hist(outcome_hist)
    );

    branch_resolve_unit #(.CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .br_valid(br_valid), .br_op(br_op),
        .br_a(br_a), .br_b(br_b), .pred_taken(pred_taken), .stats_clr(stats_clr),
        .resolve_valid(s_resolve_valid), .actual_taken(s_actual_taken),
        .mispredict(s_mispredict), .flush(s_flush), .br_cnt(s_br_cnt),
        .mispred_cnt(s_mispred_cnt), .squash_cnt(s_squash_cnt), .outcome_hist(s_outcome_hist)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] op, input logic [3:0] a,
                         input logic [3:0] b, input logic p);
        br_valid   = v;
        br_op      = op;
        br_a       = a;
        br_b       = b;
        pred_taken = p;
    endtask

    task automatic idle(input logic p);
        drive(1'b0, 2'b00, 4'd0, 4'd0, p);
    endtask

    // Leaves the bench at "cycle 0", just after an edge with inputs idle
    task automatic do_reset();
        idle(1'b0);
        stats_clr = 1'b0;
        rst_n     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_resolve"}, 32'(resolve_valid), 32'd0);
        check({tag, "_actual"},  32'(actual_taken),  32'd0);
        check({tag, "_mispred"}, 32'(mispredict),    32'd0);
        check({tag, "_flush"},   32'(flush),         32'd0);
        check({tag, "_brcnt"},   32'(br_cnt),        32'd0);
        check({tag, "_mpcnt"},   32'(mispred_cnt),   32'd0);
        check({tag, "_sqcnt"},   32'(squash_cnt),    32'd0);
        check({tag, "_hist"},    32'(outcome_hist),  32'd0);
    endtask

    initial begin
        // Reset and idle
        do_reset();
        check_quiet("rst");
        for (int i = 0; i < 5; i++) begin
            next_cycle();
            check($sformatf("idle%0d_flush", i), 32'(flush), 32'd0);
            check($sformatf("idle%0d_resolve", i), 32'(resolve_valid), 32'd0);
        end

        // BEQ 3,3 predicted not-taken: mispredict and 3-cycle flush
        do_reset();
        next_cycle(); drive(1'b1, 2'b00, 4'd3, 4'd3, 1'b0);       // c1
        next_cycle(); idle(1'b0);                                  // c2
        check("beq_c2_resolve", 32'(resolve_valid), 32'd0);
        next_cycle(); idle(1'b0);                                  // c3
        check("beq_c3_resolve", 32'(resolve_valid), 32'd1);
        check("beq_c3_actual",  32'(actual_taken),  32'd1);
        check("beq_c3_mispred", 32'(mispredict),    32'd1);
        check("beq_c3_flush",   32'(flush),         32'd1);
        check("beq_c3_brcnt",   32'(br_cnt),        32'd1);
        check("beq_c3_mpcnt",   32'(mispred_cnt),   32'd1);
        next_cycle();                                              // c4
        check("beq_c4_resolve", 32'(resolve_valid), 32'd0);
        check("beq_c4_mispred", 32'(mispredict),    32'd0);
        check("beq_c4_actual_hold", 32'(actual_taken), 32'd1);
        check("beq_c4_flush",   32'(flush),         32'd1);
        next_cycle();                                              // c5
        check("beq_c5_flush",   32'(flush),         32'd1);
        next_cycle();                                              // c6
        check("beq_c6_flush",   32'(flush),         32'd0);

        // BLT correctly predicted, then BGE mispredicted
        do_reset();
        next_cycle(); drive(1'b1, 2'b10, 4'd2, 4'd9, 1'b0);       // c1
        next_cycle(); idle(1'b1);                                  // c2
        next_cycle(); idle(1'b0);                                  // c3
        check("blt_c3_resolve", 32'(resolve_valid), 32'd1);
        check("blt_c3_actual",  32'(actual_taken),  32'd1);
        check("blt_c3_mispred", 32'(mispredict),    32'd0);
        check("blt_c3_flush",   32'(flush),         32'd0);
        next_cycle(); drive(1'b1, 2'b11, 4'd4, 4'd9, 1'b0);       // c4
        check("blt_c4_flush",   32'(flush),         32'd0);
        next_cycle(); idle(1'b1);                                  // c5
        next_cycle(); idle(1'b0);                                  // c6
        check("bge_c6_resolve", 32'(resolve_valid), 32'd1);
        check("bge_c6_actual",  32'(actual_taken),  32'd0);
        check("bge_c6_mispred", 32'(mispredict),    32'd1);
        check("bge_c6_flush",   32'(flush),         32'd1);
        check("bge_c6_brcnt",   32'(br_cnt),        32'd2);
        check("bge_c6_mpcnt",   32'(mispred_cnt),   32'd1);

        // Mispredicting BNE followed by three BEQs: one stage-2 and two stage-1 squashes
        do_reset();
        next_cycle(); drive(1'b1, 2'b01, 4'd5, 4'd5, 1'b0);       // c1
        next_cycle(); drive(1'b1, 2'b00, 4'd1, 4'd1, 1'b1);       // c2
        next_cycle(); drive(1'b1, 2'b00, 4'd2, 4'd2, 1'b0);       // c3
        check("sq_c3_mispred", 32'(mispredict),  32'd1);
        check("sq_c3_actual",  32'(actual_taken), 32'd0);
        check("sq_c3_flush",   32'(flush),        32'd1);
        check("sq_c3_sqcnt",   32'(squash_cnt),   32'd0);
        next_cycle(); drive(1'b1, 2'b00, 4'd3, 4'd3, 1'b0);       // c4
        check("sq_c4_sqcnt",   32'(squash_cnt),   32'd2);
        check("sq_c4_resolve", 32'(resolve_valid), 32'd0);
        next_cycle(); idle(1'b0);                                  // c5
        check("sq_c5_sqcnt",   32'(squash_cnt),   32'd3);
        check("sq_c5_flush",   32'(flush),        32'd1);
        next_cycle();                                              // c6
        check("sq_c6_flush",   32'(flush),        32'd0);
        check("sq_c6_resolve", 32'(resolve_valid), 32'd0);
        check("sq_c6_sqcnt",   32'(squash_cnt),   32'd3);
        check("sq_c6_brcnt",   32'(br_cnt),       32'd1);
        check("sq_c6_mpcnt",   32'(mispred_cnt),  32'd1);

        // Saturation on the CNT_W=2 instance, then a clear colliding with a resolve
        do_reset();
        for (int i = 1; i <= 6; i++) begin
            next_cycle();                                          // c1..c6
            drive(1'b1, 2'b00, 4'(i), 4'(i), 1'b1);
            if (i >= 3) begin
                check($sformatf("sat_c%0d_resolve", i), 32'(s_resolve_valid), 32'd1);
                check($sformatf("sat_c%0d_brcnt", i), 32'(s_br_cnt), 32'((i - 2 > 3) ? 3 : i - 2));
            end
        end
        next_cycle(); idle(1'b1); stats_clr = 1'b1;                // c7
        check("sat_c7_brcnt",     32'(s_br_cnt),  32'd3);
        check("sat_c7_brcnt_wide", 32'(br_cnt),   32'd5);
        check("sat_c7_flush",     32'(s_flush),   32'd0);
        next_cycle(); stats_clr = 1'b0;                            // c8
        check("clr_c8_resolve",   32'(s_resolve_valid), 32'd1);
        check("clr_c8_brcnt",     32'(s_br_cnt),  32'd0);
        check("clr_c8_brcnt_wide", 32'(br_cnt),   32'd0);
        next_cycle();                                              // c9
        check("clr_c9_brcnt",     32'(s_br_cnt),  32'd0);
        check("clr_c9_mpcnt",     32'(s_mispred_cnt), 32'd0);

        // Reset asserted in flush cycle 2, then normal operation resumes
        do_reset();
        next_cycle(); drive(1'b1, 2'b00, 4'd3, 4'd3, 1'b0);       // c1
        next_cycle(); drive(1'b1, 2'b00, 4'd1, 4'd1, 1'b0);       // c2
        next_cycle(); idle(1'b0);                                  // c3
        check("rf_c3_flush",   32'(flush),      32'd1);
        next_cycle();                                              // c4
        check("rf_c4_flush",   32'(flush),      32'd1);
        check("rf_c4_sqcnt",   32'(squash_cnt), 32'd1);
        rst_n = 1'b0;
        #1;
        check_quiet("rf_async");
        @(posedge clk);
        #1;
        rst_n = 1'b1;                                              // c0
        next_cycle(); drive(1'b1, 2'b01, 4'd1, 4'd2, 1'b0);       // c1
        next_cycle(); idle(1'b1);                                  // c2
        check("rf_c2_resolve", 32'(resolve_valid), 32'd0);
        next_cycle(); idle(1'b0);                                  // c3
        check("rf_c3b_resolve", 32'(resolve_valid), 32'd1);
        check("rf_c3b_actual",  32'(actual_taken),  32'd1);
        check("rf_c3b_mispred", 32'(mispredict),    32'd0);
        check("rf_c3b_flush",   32'(flush),         32'd0);
        check("rf_c3b_brcnt",   32'(br_cnt),        32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
